// File: rtl/chess_pkg.sv
// chess_pkg: shared types and constants for the chess clock turn controller.
//   state_t          game FSM state (IDLE, RUN1, RUN2, OVER)
//   TIME_W           width of the per-player remaining-time values
//   DIV_DEFAULT      default CLK cycles per one-second decrement tick
//   DEB_LEN_DEFAULT  default number of stable samples to accept a button level
//   is_run()         true for the two states in which a clock is running
package chess_pkg;

  localparam int TIME_W          = 4;
  localparam int DIV_DEFAULT     = 50_000_000;
  localparam int DEB_LEN_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN1 = 2'd1,
    RUN2 = 2'd2,
    OVER = 2'd3
  } state_t;

  function automatic logic is_run(input state_t s);
    return (s == RUN1) || (s == RUN2);
  endfunction

endpackage

// File: rtl/chess_turn_ctrl_btn_debounce.sv
// btn_debounce: synchronizes a raw asynchronous push button, accepts a new
// level only after DEB_LEN consecutive identical synchronized samples, and
// emits a single-cycle pulse when the accepted level goes 0 -> 1.
//   CLK    system clock
//   CLR    asynchronous active-high reset (all state to 0)
//   BTN    raw asynchronous button input
//   PRESS  registered one-cycle pulse on an accepted press
module btn_debounce
  import chess_pkg::*;
#(
  parameter int DEB_LEN = DEB_LEN_DEFAULT
) (
  input  logic CLK,
  input  logic CLR,
  input  logic BTN,
  output logic PRESS
);

  localparam int CNT_W = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  // cnt holds how many consecutive samples before this one already differed
  // from the accepted level; the DEB_LEN-th differing sample is accepted.
  assign differ = (sync2 != stable);
  assign accept = differ && (cnt == CNT_W'(DEB_LEN - 1));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      PRESS  <= 1'b0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
      if (!differ) begin
        cnt <= '0;
      end else if (accept) begin
        cnt    <= '0;
        stable <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      PRESS <= accept && sync2;
    end
  end

endmodule

// File: rtl/chess_turn_ctrl.sv
// chess_turn_ctrl: turn and tick controller feeding the two-player chess
// clock down-counter. Debounces both turn buttons, divides CLK to the
// decrement tick, runs the game FSM and watches the fed-back times for a
// flag fall.
//   CLK, CLR     clock; asynchronous active-high reset
//   START        level; IDLE -> RUN1 and OVER -> IDLE
//   BTN1, BTN2   raw player buttons (end own turn)
//   TIM1, TIM2   remaining times read back from the counter
//   CE           registered one-cycle decrement enable
//   PLAYER       registered; 1 = player 1 running, 0 = player 2
//   STOP         registered; 1 in IDLE and OVER
//   FLAG1/FLAG2  registered sticky time-out flags, cleared on leaving OVER
//   dbg_state    current FSM state for observation
module chess_turn_ctrl
  import chess_pkg::*;
#(
  parameter int DIV     = DIV_DEFAULT,
  parameter int DEB_LEN = DEB_LEN_DEFAULT
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic              BTN1,
  input  logic              BTN2,
  input  logic [TIME_W-1:0] TIM1,
  input  logic [TIME_W-1:0] TIM2,
  output logic              CE,
  output logic              PLAYER,
  output logic              STOP,
  output logic              FLAG1,
  output logic              FLAG2,
  output state_t            dbg_state
);

  localparam int PRE_W = $clog2(DIV);

  state_t           state;
  state_t           state_next;
  logic [PRE_W-1:0] pres;
  logic [PRE_W-1:0] pres_next;
  logic             tick;
  logic             press1;
  logic             press2;
  logic             flag1_next;
  logic             flag2_next;
  logic             ce_next;
  logic             player_next;
  logic             stop_next;
  logic             active_nz;

  btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb1 (
    .CLK   (CLK),
    .CLR   (CLR),
    .BTN   (BTN1),
    .PRESS (press1)
  );

  btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb2 (
    .CLK   (CLK),
    .CLR   (CLR),
    .BTN   (BTN2),
    .PRESS (press2)
  );

  assign tick      = (pres == PRE_W'(DIV - 1));
  assign dbg_state = state;

  always_comb begin
    state_next  = state;
    flag1_next  = FLAG1;
    flag2_next  = FLAG2;
    active_nz   = 1'b0;
    player_next = PLAYER;
    pres_next   = '0;

    // The flag check is tested before the button so a press arriving with
    // the active time already at zero still ends the game.
    case (state)
      IDLE: if (START) state_next = RUN1;
      RUN1: begin
        if (TIM1 == '0) begin
          state_next = OVER;
          flag1_next = 1'b1;
        end else if (press1) begin
          state_next = RUN2;
        end
      end
      RUN2: begin
        if (TIM2 == '0) begin
          state_next = OVER;
          flag2_next = 1'b1;
        end else if (press2) begin
          state_next = RUN1;
        end
      end
      OVER: begin
        if (START) begin
          state_next = IDLE;
          flag1_next = 1'b0;
          flag2_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    // The prescaler only advances while a clock runs across the edge, so it
    // is 0 on entry to RUN1 and drops to 0 as soon as the game ends; a turn
    // switch keeps the fractional second.
    if (is_run(state) && is_run(state_next)) begin
      pres_next = tick ? '0 : pres + PRE_W'(1);
    end

    // Outputs follow the next state; CE is withheld when the time that
    // would be decremented is already 0, so the counter never wraps.
    case (state_next)
      RUN1: begin
        active_nz   = (TIM1 != '0);
        player_next = 1'b1;
      end
      RUN2: begin
        active_nz   = (TIM2 != '0);
        player_next = 1'b0;
      end
      IDLE:    player_next = 1'b1;
      default: player_next = PLAYER;
    endcase

    ce_next   = tick && active_nz;
    stop_next = !is_run(state_next);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state  <= IDLE;
      pres   <= '0;
      CE     <= 1'b0;
      PLAYER <= 1'b1;
      STOP   <= 1'b1;
      FLAG1  <= 1'b0;
      FLAG2  <= 1'b0;
    end else begin
      state  <= state_next;
      pres   <= pres_next;
      CE     <= ce_next;
      PLAYER <= player_next;
      STOP   <= stop_next;
      FLAG1  <= flag1_next;
      FLAG2  <= flag2_next;
    end
  end

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// tb_chess_turn_ctrl: self-checking bench for chess_turn_ctrl with DIV=4 and
// DEB_LEN=3. A behavioural model of the game rules (phases, raw-sample
// history windows for the buttons, a running-cycle count for the ticks and
// a model of the external counter) is compared with the DUT every cycle,
// and directed scenarios pin key latencies with literal expectations.
module tb_chess_turn_ctrl;
  import chess_pkg::*;

  localparam int DIV = 4;
  localparam int DEB = 3;
  localparam int PH_IDLE = 0, PH_RUN1 = 1, PH_RUN2 = 2, PH_OVER = 3;

  // ---------------- clock / reset / DUT ----------------
  logic       CLK = 1'b0;
  logic       CLR, START, BTN1, BTN2;
  logic [3:0] TIM1, TIM2;
  logic       CE, PLAYER, STOP, FLAG1, FLAG2;
  state_t     dbg_state;

  int tim1, tim2;
  assign TIM1 = tim1[3:0];
  assign TIM2 = tim2[3:0];

  always #5 CLK = ~CLK;

  chess_turn_ctrl #(.DIV(DIV), .DEB_LEN(DEB)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .START     (START),
    .BTN1      (BTN1),
    .BTN2      (BTN2),
    .TIM1      (TIM1),
    .TIM2      (TIM2),
    .CE        (CE),
    .PLAYER    (PLAYER),
    .STOP      (STOP),
    .FLAG1     (FLAG1),
    .FLAG2     (FLAG2),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int m_phase, m_run_cycles;
  bit m_ce, m_player, m_stop, m_f1, m_f2;
  bit m_press [0:1];
  bit m_level [0:1];
  bit m_hist  [0:1][0:DEB+1];   // raw samples, oldest at index 0
  bit dec1, dec2;

  task automatic m_reset();
    m_phase = PH_IDLE; m_run_cycles = 0;
    m_ce = 0; m_player = 1; m_stop = 1; m_f1 = 0; m_f2 = 0;
    for (int b = 0; b < 2; b++) begin
      m_press[b] = 0; m_level[b] = 0;
      for (int i = 0; i < DEB + 2; i++) m_hist[b][i] = 0;
    end
  endtask

  task automatic m_step();
    int  t1, t2, nph;
    bit  running, nrun, tick, all_new;
    bit  raw [0:1];
    t1 = tim1; t2 = tim2;
    running = (m_phase == PH_RUN1) || (m_phase == PH_RUN2);
    tick = running && ((m_run_cycles % DIV) == DIV - 1);
    nph = m_phase;
    case (m_phase)
      PH_IDLE: if (START) nph = PH_RUN1;
      PH_RUN1: if (t1 == 0) begin nph = PH_OVER; m_f1 = 1; end
               else if (m_press[0]) nph = PH_RUN2;
      PH_RUN2: if (t2 == 0) begin nph = PH_OVER; m_f2 = 1; end
               else if (m_press[1]) nph = PH_RUN1;
      default: if (START) begin nph = PH_IDLE; m_f1 = 0; m_f2 = 0; end
    endcase
    nrun = (nph == PH_RUN1) || (nph == PH_RUN2);
    m_run_cycles = (running && nrun) ? m_run_cycles + 1 : 0;
    // external counter decrements on the CE that is visible before this edge
    dec1 = m_ce && m_player;
    dec2 = m_ce && !m_player;
    m_ce = tick && ((nph == PH_RUN1 && t1 != 0) || (nph == PH_RUN2 && t2 != 0));
    if (nph == PH_RUN1 || nph == PH_IDLE) m_player = 1;
    else if (nph == PH_RUN2) m_player = 0;
    m_stop = !nrun;
    m_phase = nph;
    // buttons: a new level is taken when the DEB samples that are two
    // synchronizer stages old all disagree with the current level
    raw[0] = BTN1; raw[1] = BTN2;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < DEB + 1; i++) m_hist[b][i] = m_hist[b][i+1];
      m_hist[b][DEB+1] = raw[b];
      all_new = 1;
      for (int i = 0; i < DEB; i++) if (m_hist[b][i] == m_level[b]) all_new = 0;
      m_press[b] = all_new && !m_level[b];
      if (all_new) m_level[b] = !m_level[b];
    end
  endtask

  always @(posedge CLK) begin
    if (!CLR) begin
      m_step();
      #1;
      if (dec1 && tim1 > 0) tim1 = tim1 - 1;
      if (dec2 && tim2 > 0) tim2 = tim2 - 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("ce",     int'(CE),        int'(m_ce));
      chk("player", int'(PLAYER),    int'(m_player));
      chk("stop",   int'(STOP),      int'(m_stop));
      chk("flag1",  int'(FLAG1),     int'(m_f1));
      chk("flag2",  int'(FLAG2),     int'(m_f2));
      chk("state",  int'(dbg_state), m_phase);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic pulse_start();
    START = 1; cyc(1); START = 0;
  endtask

  task automatic wait_ce(input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      cyc(1); n++;
      if (CE) return;
    end
    n = 999;
  endtask

  // hold for n cycles; count PLAYER changes and the cycle of the first one
  task automatic count_switches(input int n, output int sw, output int first);
    logic prev;
    sw = 0; first = 0; prev = PLAYER;
    for (int i = 1; i <= n; i++) begin
      cyc(1);
      if (PLAYER != prev) begin
        sw++;
        if (sw == 1) first = i;
        prev = PLAYER;
      end
    end
  endtask

  task automatic do_reset();
    CLR = 1; m_reset(); cyc(2); CLR = 0; cyc(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, sw, first, nce;
    CLR = 1; START = 0; BTN1 = 0; BTN2 = 0; tim1 = 15; tim2 = 15;
    m_reset();
    cyc(2);
    CLR = 0;
    cyc(1);
    cmp_en = 1;

    // reset values, then start with first CE DIV cycles into RUN1
    chk("rst_ce", int'(CE), 0);
    chk("rst_player", int'(PLAYER), 1);
    chk("rst_stop", int'(STOP), 1);
    chk("rst_flags", int'({FLAG1, FLAG2}), 0);
    pulse_start();
    chk("start_state", int'(dbg_state), int'(RUN1));
    chk("start_stop", int'(STOP), 0);
    wait_ce(20, n);
    chk("first_ce_latency", n, DIV);

    // held BTN1: exactly one switch, DEB+3 cycles after the press
    BTN1 = 1;
    count_switches(10, sw, first);
    chk("hold_one_switch", sw, 1);
    chk("hold_switch_latency", first, DEB + 3);
    BTN1 = 0; cyc(6);
    BTN1 = 1;
    count_switches(8, sw, first);
    chk("wrong_player_ignored", sw, 0);
    BTN1 = 0; cyc(6);

    // bounce on BTN2 in RUN2, then settle high
    sw = 0;
    for (int i = 0; i < 6; i++) begin
      int s1;
      int f1;
      BTN2 = !BTN2;
      count_switches(1, s1, f1);
      sw += s1;
    end
    chk("bounce_no_switch", sw, 0);
    BTN2 = 1;
    count_switches(10, sw, first);
    chk("bounce_one_switch", sw, 1);
    chk("bounce_latency", first, DEB + 3);
    BTN2 = 0; cyc(6);

    // both buttons together in RUN1
    tim1 = 15; tim2 = 15;
    BTN1 = 1; BTN2 = 1;
    count_switches(12, sw, first);
    chk("both_one_switch", sw, 1);
    chk("both_player", int'(PLAYER), 0);
    BTN1 = 0; BTN2 = 0; cyc(6);

    // flag fall for player 2 from TIM2=2
    n = 0;
    while (CE && n < 10) begin cyc(1); n++; end
    tim2 = 2;
    nce = 0; n = 0;
    while (!STOP && n < 40) begin
      cyc(1); n++;
      if (CE) nce++;
    end
    chk("flag2_ce_count", nce, 2);
    chk("flag2_set", int'(FLAG2), 1);
    chk("flag2_stop", int'(STOP), 1);
    chk("flag2_state", int'(dbg_state), int'(OVER));
    nce = 0;
    for (int i = 0; i < 10; i++) begin cyc(1); if (CE) nce++; end
    chk("no_ce_after_flag", nce, 0);
    chk("tim2_no_wrap", tim2, 0);

    // leave OVER, then press1 coinciding with TIM1=0
    pulse_start();
    chk("over_exit_flags", int'({FLAG1, FLAG2}), 0);
    tim1 = 15; tim2 = 15;
    pulse_start();
    BTN1 = 1;
    cyc(5);
    tim1 = 0;
    cyc(1);
    chk("press_vs_flag_state", int'(dbg_state), int'(OVER));
    chk("press_vs_flag_f1", int'(FLAG1), 1);
    chk("press_vs_flag_f2", int'(FLAG2), 0);
    BTN1 = 0;
    pulse_start();
    // START with the active time already zero
    pulse_start();
    chk("zero_start_run1", int'(dbg_state), int'(RUN1));
    cyc(1);
    chk("zero_start_over", int'(dbg_state), int'(OVER));
    chk("zero_start_flag1", int'(FLAG1), 1);
    cyc(4);

    // asynchronous CLR mid-game in RUN2
    tim1 = 15; tim2 = 15;
    pulse_start(); pulse_start();
    BTN1 = 1;
    n = 0;
    while (PLAYER && n < 20) begin cyc(1); n++; end
    BTN1 = 0;
    chk("clr_setup_run2", int'(dbg_state), int'(RUN2));
    cyc(3);
    #1;
    CLR = 1; m_reset();
    #1;
    chk("clr_async_ce", int'(CE), 0);
    chk("clr_async_player", int'(PLAYER), 1);
    chk("clr_async_stop", int'(STOP), 1);
    chk("clr_async_state", int'(dbg_state), int'(IDLE));
    cyc(2);
    CLR = 0;
    cyc(1);
    pulse_start();
    wait_ce(20, n);
    chk("clr_prescaler_zero", n, DIV);

    // randomized play against the model
    BTN1 = 0; BTN2 = 0;
    cyc(6);
    for (int i = 0; i < 600; i++) begin
      START = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 5) == 0) BTN1 = !BTN1;
      if ($urandom_range(0, 5) == 0) BTN2 = !BTN2;
      if ((m_phase == PH_IDLE || m_phase == PH_OVER) && $urandom_range(0, 2) == 0) begin
        tim1 = $urandom_range(0, 6);
        tim2 = $urandom_range(0, 6);
      end
      cyc(1);
    end
    START = 0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
